// File: rtl/rv32i_mc_control_unit_pkg.sv
// Shared types and constants for the RV32I multi-cycle control unit:
// FSM states, trap causes, datapath mux selects and opcode classification.
package rv32i_mc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } RV32I_MC_STATE_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL     = 2'd0,
        CAUSE_ECALL       = 2'd1,
        CAUSE_EBREAK      = 2'd2,
        CAUSE_BUS_TIMEOUT = 2'd3
    } TRAP_CAUSE_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } PC_SEL_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } WB_SEL_t;

    typedef enum logic [3:0] {
        CLS_NULL = 4'd0,
        CLS_R    = 4'd1,
        CLS_I    = 4'd2,
        CLS_LOAD = 4'd3,
        CLS_JALR = 4'd4,
        CLS_ENV  = 4'd5,
        CLS_S    = 4'd6,
        CLS_B    = 4'd7,
        CLS_J    = 4'd8,
        CLS_LUI  = 4'd9,
        CLS_AUI  = 4'd10
    } OP_CLASS_t;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_R    = 7'h33;
    localparam opcode_t OPC_I    = 7'h13;
    localparam opcode_t OPC_LOAD = 7'h03;
    localparam opcode_t OPC_JALR = 7'h67;
    localparam opcode_t OPC_ENV  = 7'h73;
    localparam opcode_t OPC_S    = 7'h23;
    localparam opcode_t OPC_B    = 7'h63;
    localparam opcode_t OPC_J    = 7'h6F;
    localparam opcode_t OPC_LUI  = 7'h37;
    localparam opcode_t OPC_AUI  = 7'h17;

    // Anything not in the supported subset (FENCE included) maps to CLS_NULL.
    function automatic OP_CLASS_t classify(input opcode_t op);
        case (op)
            OPC_R:    return CLS_R;
            OPC_I:    return CLS_I;
            OPC_LOAD: return CLS_LOAD;
            OPC_JALR: return CLS_JALR;
            OPC_ENV:  return CLS_ENV;
            OPC_S:    return CLS_S;
            OPC_B:    return CLS_B;
            OPC_J:    return CLS_J;
            OPC_LUI:  return CLS_LUI;
            OPC_AUI:  return CLS_AUI;
            default:  return CLS_NULL;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_mc_control_unit_if.sv
// Memory request/acknowledge bus between the control unit and the memory port.
interface rv32i_mc_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_fetch;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ack);
endinterface

// File: rtl/rv32i_mem_watchdog.sv
// Wait-state watchdog: flags a timeout on the MEM_TIMEOUT-th consecutive
// waiting cycle. MEM_TIMEOUT=0 leaves it permanently inert.
module rv32i_mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, waiting, clear};
            assign timeout = 1'b0;
        end else begin : g_on
            localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
            logic [W-1:0] wait_cnt_q;
            logic [W-1:0] wait_cnt_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end

            always_comb begin
                wait_cnt_d = wait_cnt_q;
                if (clear) begin
                    wait_cnt_d = '0;
                end else if (waiting) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            // wait_cnt_q holds the number of earlier waiting cycles, so this is
            // the limit cycle; an ack in that same cycle drops waiting and wins.
            assign timeout = waiting && (wait_cnt_q == W'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback with
// a sticky trap state, memory wait watchdog and retired-instruction counter.
module rv32i_mc_control_unit
    import rv32i_mc_control_unit_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int MEM_TIMEOUT    = 15,
    parameter bit HALT_ON_EBREAK = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    rv32i_mc_control_unit_if.master bus,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    sys_bit,
    input  logic                    branch_taken,
    output logic                    ir_we,
    output logic                    pc_we,
    output PC_SEL_t                 pc_sel,
    output logic                    rf_we,
    output WB_SEL_t                 wb_sel,
    output logic                    alu_a_pc,
    output logic                    alu_b_imm,
    output RV32I_MC_STATE_t         state,
    output logic                    trap,
    output TRAP_CAUSE_t             trap_cause,
    output logic                    retired,
    output logic [CNT_W-1:0]        retire_cnt
);

    RV32I_MC_STATE_t state_q, state_d;
    OP_CLASS_t       class_q, class_d;
    TRAP_CAUSE_t     cause_q, cause_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    OP_CLASS_t dec_class;
    logic      mem_req;
    logic      mem_we;
    logic      mem_is_fetch;
    logic      timeout;
    logic      ebreak_nop;

    assign dec_class  = classify(opcode);
    assign ebreak_nop = !HALT_ON_EBREAK && (dec_class == CLS_ENV)
                        && (funct3 == 3'd0) && sys_bit;

    rv32i_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (mem_req && !bus.mem_ack),
        .clear   (bus.mem_ack || (state_d != state_q)),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET;
            class_q      <= CLS_NULL;
            cause_q      <= CAUSE_ILLEGAL;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            cause_q      <= cause_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        cause_d      = cause_q;
        retire_cnt_d = retire_cnt_q + CNT_W'(retired);
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS_TIMEOUT;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_class == CLS_NULL) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_class == CLS_ENV) begin
                    if (funct3 != 3'd0) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (!sys_bit) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ECALL;
                    end else if (HALT_ON_EBREAK) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_EBREAK;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (class_q == CLS_B) begin
                    state_d = ST_FETCH;
                end else if ((class_q == CLS_LOAD) || (class_q == CLS_S)) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (bus.mem_ack) begin
                    state_d = (class_q == CLS_S) ? ST_FETCH : ST_WRITEBACK;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS_TIMEOUT;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_RESET;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        alu_a_pc     = 1'b0;
        alu_b_imm    = 1'b0;
        retired      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                ir_we        = bus.mem_ack;
            end
            ST_DECODE: begin
                pc_we   = ebreak_nop;
                retired = ebreak_nop;
            end
            ST_EXECUTE: begin
                alu_a_pc  = (class_q == CLS_AUI) || (class_q == CLS_B) || (class_q == CLS_J);
                alu_b_imm = (class_q != CLS_R) && (class_q != CLS_B);
                if (class_q == CLS_B) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
                    retired = 1'b1;
                end
            end
            ST_MEMORY: begin
                mem_req = 1'b1;
                mem_we  = (class_q == CLS_S);
                if (bus.mem_ack && (class_q == CLS_S)) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retired = 1'b1;
                case (class_q)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_J:    wb_sel = WB_PC4;
                    CLS_JALR: wb_sel = WB_PC4;
                    default:  wb_sel = WB_ALU;
                endcase
                case (class_q)
                    CLS_J:    pc_sel = PC_JAL;
                    CLS_JALR: pc_sel = PC_JALR;
                    default:  pc_sel = PC_PLUS4;
                endcase
            end
            default: ;
        endcase
    end

    // Request lines decode straight from state_q so an async reset drops them at once.
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_is_fetch = mem_is_fetch;

    assign state      = state_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_rv32i_mc_control_unit;
    import rv32i_mc_control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sys_bit;
    logic       branch_taken;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rv32i_mc_control_unit_if bus_a ();
    rv32i_mc_control_unit_if bus_b ();

    logic ir_we_a, pc_we_a, rf_we_a, alu_a_pc_a, alu_b_imm_a, trap_a, retired_a;
    PC_SEL_t pc_sel_a;
    WB_SEL_t wb_sel_a;
    RV32I_MC_STATE_t state_a;
    TRAP_CAUSE_t trap_cause_a;
    logic [3:0] retire_cnt_a;

    logic ir_we_b, pc_we_b, rf_we_b, alu_a_pc_b, alu_b_imm_b, trap_b, retired_b;
    PC_SEL_t pc_sel_b;
    WB_SEL_t wb_sel_b;
    RV32I_MC_STATE_t state_b;
    TRAP_CAUSE_t trap_cause_b;
    logic [31:0] retire_cnt_b;

    rv32i_mc_control_unit #(.CNT_W(4), .MEM_TIMEOUT(15), .HALT_ON_EBREAK(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .opcode(opcode), .funct3(funct3),
        .sys_bit(sys_bit), .branch_taken(branch_taken), .ir_we(ir_we_a), .pc_we(pc_we_a),
        .pc_sel(pc_sel_a), .rf_we(rf_we_a), .wb_sel(wb_sel_a), .alu_a_pc(alu_a_pc_a),
        .alu_b_imm(alu_b_imm_a), .state(state_a), .trap(trap_a), .trap_cause(trap_cause_a),
        .retired(retired_a), .retire_cnt(retire_cnt_a)
    );

    rv32i_mc_control_unit dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .opcode(opcode), .funct3(funct3),
        .sys_bit(sys_bit), .branch_taken(branch_taken), .ir_we(ir_we_b), .pc_we(pc_we_b),
        .pc_sel(pc_sel_b), .rf_we(rf_we_b), .wb_sel(wb_sel_b), .alu_a_pc(alu_a_pc_b),
        .alu_b_imm(alu_b_imm_b), .state(state_b), .trap(trap_b), .trap_cause(trap_cause_b),
        .retired(retired_b), .retire_cnt(retire_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (state_a == ST_TRAP) begin
            vec_cnt++;
            if ({bus_a.mem_req, pc_we_a, rf_we_a, retired_a} !== 4'b0000) begin
                miss_cnt++;
                $error("FAIL mon_trap_a: enables active in TRAP");
            end
        end
        if (state_b == ST_TRAP) begin
            vec_cnt++;
            if ({bus_b.mem_req, pc_we_b, rf_we_b, retired_b} !== 4'b0000) begin
                miss_cnt++;
                $error("FAIL mon_trap_b: enables active in TRAP");
            end
        end
        if (state_a == ST_RESET) begin
            vec_cnt++;
            if ({bus_a.mem_req, pc_we_a, retired_a} !== 3'b000) begin
                miss_cnt++;
                $error("FAIL mon_reset_a: outputs active in RESET");
            end
        end
        if (bus_a.mem_we === 1'b1) begin
            vec_cnt++;
            if (bus_a.mem_req !== 1'b1) begin
                miss_cnt++;
                $error("FAIL mon_we_a: mem_we without mem_req");
            end
        end
    end

    task automatic set_ack(input logic v);
        bus_a.mem_ack = v;
        bus_b.mem_ack = v;
    endtask

    task automatic do_fetch(input int waits, input logic [6:0] op, input logic [2:0] f3,
                            input logic sb);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            set_ack(1'b0);
            #1;
            `CHK("fetch_wait_state", state_a, ST_FETCH);
            `CHK("fetch_wait_ir_we", ir_we_a, 0);
        end
        @(negedge clk);
        opcode = op; funct3 = f3; sys_bit = sb;
        set_ack(1'b1);
        #1;
        `CHK("fetch_state", state_a, ST_FETCH);
        `CHK("fetch_req", bus_a.mem_req, 1);
        `CHK("fetch_is_fetch", bus_a.mem_is_fetch, 1);
        `CHK("fetch_ir_we", ir_we_a, 1);
        @(negedge clk);
        set_ack(1'b0);
        #1;
        `CHK("decode_state", state_a, ST_DECODE);
        `CHK("decode_req", bus_a.mem_req, 0);
    endtask

    task automatic reset_pulse;
        @(negedge clk);
        rst = 1'b1;
        #1;
        `CHK("rst_state", state_a, ST_RESET);
        `CHK("rst_trap", trap_a, 0);
        `CHK("rst_cnt", retire_cnt_a, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; sys_bit = 1'b0; branch_taken = 1'b0;
        set_ack(1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        `CHK("reset_state_a", state_a, ST_RESET);
        `CHK("reset_state_b", state_b, ST_RESET);
        `CHK("reset_mem_req", bus_a.mem_req, 0);
        `CHK("reset_pc_we", pc_we_a, 0);
        `CHK("reset_trap", trap_a, 0);
        `CHK("reset_cause", trap_cause_a, CAUSE_ILLEGAL);
        `CHK("reset_cnt", retire_cnt_a, 0);
        rst = 1'b0;

        do_fetch(1, 7'h13, 3'd0, 1'b0);
        @(negedge clk); #1;
        `CHK("addi_exec_state", state_a, ST_EXECUTE);
        `CHK("addi_alu_b_imm", alu_b_imm_a, 1);
        `CHK("addi_alu_a_pc", alu_a_pc_a, 0);
        @(negedge clk); #1;
        `CHK("addi_wb_state", state_a, ST_WRITEBACK);
        `CHK("addi_rf_we", rf_we_a, 1);
        `CHK("addi_wb_sel", wb_sel_a, WB_ALU);
        `CHK("addi_pc_we", pc_we_a, 1);
        `CHK("addi_retired", retired_a, 1);
        `CHK("addi_cnt_before", retire_cnt_a, 0);

        do_fetch(0, 7'h03, 3'd2, 1'b0);
        `CHK("addi_cnt_after", retire_cnt_a, 1);
        @(negedge clk); #1;
        `CHK("lw_exec_imm", alu_b_imm_a, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            `CHK("lw_mem_state", state_a, ST_MEMORY);
            `CHK("lw_mem_req", bus_a.mem_req, 1);
            `CHK("lw_mem_we", bus_a.mem_we, 0);
        end
        @(negedge clk); set_ack(1'b1); #1;
        `CHK("lw_ack_req", bus_a.mem_req, 1);
        `CHK("lw_ack_retired", retired_a, 0);
        @(negedge clk); set_ack(1'b0); #1;
        `CHK("lw_wb_state", state_a, ST_WRITEBACK);
        `CHK("lw_wb_sel", wb_sel_a, WB_MEM);
        `CHK("lw_rf_we", rf_we_a, 1);

        do_fetch(0, 7'h23, 3'd2, 1'b0);
        `CHK("lw_cnt", retire_cnt_a, 2);
        @(negedge clk); #1;
        @(negedge clk); set_ack(1'b1); #1;
        `CHK("sw_mem_state", state_a, ST_MEMORY);
        `CHK("sw_mem_we", bus_a.mem_we, 1);
        `CHK("sw_pc_we", pc_we_a, 1);
        `CHK("sw_retired", retired_a, 1);
        `CHK("sw_rf_we", rf_we_a, 0);

        do_fetch(0, 7'h63, 3'd0, 1'b0);
        `CHK("sw_cnt", retire_cnt_a, 3);
        @(negedge clk); branch_taken = 1'b1; #1;
        `CHK("beq_t_state", state_a, ST_EXECUTE);
        `CHK("beq_t_alu_a_pc", alu_a_pc_a, 1);
        `CHK("beq_t_alu_b_imm", alu_b_imm_a, 0);
        `CHK("beq_t_pc_we", pc_we_a, 1);
        `CHK("beq_t_pc_sel", pc_sel_a, PC_BRANCH);
        `CHK("beq_t_retired", retired_a, 1);

        do_fetch(0, 7'h63, 3'd0, 1'b0);
        @(negedge clk); branch_taken = 1'b0; #1;
        `CHK("beq_nt_pc_we", pc_we_a, 1);
        `CHK("beq_nt_pc_sel", pc_sel_a, PC_PLUS4);

        do_fetch(0, 7'h6F, 3'd0, 1'b0);
        `CHK("beq_cnt", retire_cnt_a, 5);
        @(negedge clk); #1;
        `CHK("jal_alu_a_pc", alu_a_pc_a, 1);
        `CHK("jal_alu_b_imm", alu_b_imm_a, 1);
        @(negedge clk); #1;
        `CHK("jal_wb_sel", wb_sel_a, WB_PC4);
        `CHK("jal_pc_sel", pc_sel_a, PC_JAL);
        `CHK("jal_rf_we", rf_we_a, 1);

        do_fetch(0, 7'h73, 3'd0, 1'b1);
        `CHK("ebreak_a_pc_we", pc_we_a, 1);
        `CHK("ebreak_a_retired", retired_a, 1);
        `CHK("ebreak_b_retired", retired_b, 0);
        `CHK("ebreak_a_cnt", retire_cnt_a, 6);
        @(negedge clk); #1;
        `CHK("ebreak_a_state", state_a, ST_FETCH);
        `CHK("ebreak_a_cnt_after", retire_cnt_a, 7);
        `CHK("ebreak_b_state", state_b, ST_TRAP);
        `CHK("ebreak_b_trap", trap_b, 1);
        `CHK("ebreak_b_cause", trap_cause_b, CAUSE_EBREAK);
        `CHK("ebreak_b_cnt", retire_cnt_b, 6);
        `CHK("ebreak_b_mem_req", bus_b.mem_req, 0);

        for (int i = 2; i <= 15; i++) begin
            @(negedge clk); #1;
            `CHK("tmo_wait_state", state_a, ST_FETCH);
        end
        @(negedge clk); #1;
        `CHK("tmo_state", state_a, ST_TRAP);
        `CHK("tmo_trap", trap_a, 1);
        `CHK("tmo_cause", trap_cause_a, CAUSE_BUS_TIMEOUT);
        `CHK("tmo_mem_req", bus_a.mem_req, 0);
        `CHK("tmo_cnt", retire_cnt_a, 7);
        @(negedge clk); set_ack(1'b1); #1;
        `CHK("trap_sticky_state", state_a, ST_TRAP);
        `CHK("trap_sticky_ir_we", ir_we_a, 0);
        set_ack(1'b0);
        reset_pulse();

        do_fetch(14, 7'h13, 3'd0, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        `CHK("ack15_wb_retired", retired_a, 1);

        do_fetch(0, 7'h7F, 3'd0, 1'b0);
        `CHK("illegal_retired", retired_a, 0);
        @(negedge clk); #1;
        `CHK("illegal_state", state_a, ST_TRAP);
        `CHK("illegal_cause", trap_cause_a, CAUSE_ILLEGAL);
        `CHK("illegal_cnt", retire_cnt_a, 1);
        reset_pulse();

        do_fetch(0, 7'h73, 3'd0, 1'b0);
        @(negedge clk); #1;
        `CHK("ecall_a_cause", trap_cause_a, CAUSE_ECALL);
        `CHK("ecall_a_trap", trap_a, 1);
        `CHK("ecall_b_cause", trap_cause_b, CAUSE_ECALL);
        `CHK("ecall_cnt", retire_cnt_a, 0);
        reset_pulse();

        for (int k = 1; k <= 16; k++) begin
            do_fetch(0, 7'h13, 3'd0, 1'b0);
            @(negedge clk); #1;
            @(negedge clk); #1;
            `CHK("wrap_cnt_before", retire_cnt_a, (k - 1) % 16);
        end

        do_fetch(0, 7'h03, 3'd2, 1'b0);
        `CHK("wrap_cnt_zero", retire_cnt_a, 0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        `CHK("rstmid_mem_req_pre", bus_a.mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        `CHK("rstmid_state", state_a, ST_RESET);
        `CHK("rstmid_mem_req", bus_a.mem_req, 0);
        `CHK("rstmid_cnt", retire_cnt_a, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`undef CHK
